// File: rtl/sram_arbiter_pkg.sv
// Shared SRAM-bus widths, arbiter state encoding and grant ids, reused by any
// later master ports (e.g. a cache refill port) that join the arbiter.
package sram_arbiter_pkg;

  localparam int unsigned ADDR_BUS    = 32;
  localparam int unsigned DATA_BUS    = 32;
  localparam int unsigned MEM_SEL_BUS = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_LOW  = 3'd2,
    ST_WAIT_HIGH = 3'd3,
    ST_DONE      = 3'd4
  } arb_state_e;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_e;

endpackage

// File: rtl/sram_arbiter.sv
// Two-master (inst/data) to one-slave SRAM-style arbiter: one transaction in
// flight, alternating tie-break, registered ready pulse and read data per master.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_BUS,
  parameter int unsigned DATA_W = DATA_BUS,
  parameter int unsigned SEL_W  = MEM_SEL_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_en,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_ready,
  output logic [DATA_W-1:0] inst_read_data,
  input  logic              data_en,
  input  logic [SEL_W-1:0]  data_write_en,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_write_data,
  output logic              data_ready,
  output logic [DATA_W-1:0] data_read_data,
  output logic              bus_en,
  input  logic              bus_ready,
  output logic [SEL_W-1:0]  bus_write_en,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_write_data,
  input  logic [DATA_W-1:0] bus_read_data
);

  arb_state_e state, state_next;
  grant_e     grant, last_grant, grant_sel_c;
  logic       take_c, capture_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state, grant choice (data wins a tie unless it won last time).
  always_comb begin
    state_next  = state;
    take_c      = 1'b0;
    capture_c   = 1'b0;
    grant_sel_c = GRANT_INST;
    unique case (state)
      ST_IDLE: begin
        if (inst_en || data_en) begin
          take_c      = 1'b1;
          state_next  = ST_ISSUE;
          grant_sel_c = (data_en && (!inst_en || last_grant == GRANT_INST))
                        ? GRANT_DATA : GRANT_INST;
        end
      end
      ST_ISSUE:     if (bus_ready)  state_next = ST_WAIT_LOW;
      ST_WAIT_LOW:  if (!bus_ready) state_next = ST_WAIT_HIGH;
      ST_WAIT_HIGH: begin
        if (bus_ready) begin
          capture_c  = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Request latch, grant bookkeeping and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant          <= GRANT_INST;
      last_grant     <= GRANT_INST;
      bus_en         <= 1'b0;
      bus_addr       <= '0;
      bus_write_en   <= '0;
      bus_write_data <= '0;
      inst_ready     <= 1'b0;
      data_ready     <= 1'b0;
      inst_read_data <= '0;
      data_read_data <= '0;
    end else begin
      bus_en     <= (state_next == ST_ISSUE);
      inst_ready <= capture_c && (grant == GRANT_INST);
      data_ready <= capture_c && (grant == GRANT_DATA);
      if (take_c) begin
        grant <= grant_sel_c;
        if (grant_sel_c == GRANT_DATA) begin
          bus_addr       <= data_addr;
          bus_write_en   <= data_write_en;
          bus_write_data <= data_write_data;
        end else begin
          bus_addr       <= inst_addr;
          bus_write_en   <= '0;
          bus_write_data <= '0;
        end
      end
      if (capture_c && grant == GRANT_INST) inst_read_data <= bus_read_data;
      // Stores complete without disturbing the last load result.
      if (capture_c && grant == GRANT_DATA && bus_write_en == '0)
        data_read_data <= bus_read_data;
      if (state == ST_DONE) last_grant <= grant;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized
// traffic against a transaction-level arbitration model and a slave model.
module tb_sram_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_en, data_en, bus_ready;
  logic [AW-1:0] inst_addr, data_addr;
  logic [SW-1:0] data_write_en;
  logic [DW-1:0] data_write_data, bus_read_data;
  logic          inst_ready, data_ready, bus_en;
  logic [DW-1:0] inst_read_data, data_read_data, bus_write_data;
  logic [SW-1:0] bus_write_en;
  logic [AW-1:0] bus_addr;

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_ready(inst_ready),
    .inst_read_data(inst_read_data),
    .data_en(data_en), .data_write_en(data_write_en), .data_addr(data_addr),
    .data_write_data(data_write_data), .data_ready(data_ready),
    .data_read_data(data_read_data),
    .bus_en(bus_en), .bus_ready(bus_ready), .bus_write_en(bus_write_en),
    .bus_addr(bus_addr), .bus_write_data(bus_write_data),
    .bus_read_data(bus_read_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Transaction-level model of the arbiter
  bit            idle, idle_pending, in_flight, owner_data, last_data;
  logic [AW-1:0] m_addr;
  logic [SW-1:0] m_we;
  logic [DW-1:0] m_wd, m_inst_rd, m_data_rd;
  bit            exp_bus_en, exp_done;
  bit            grant_q[$];

  // Slave model and statistics
  bit            sl_accept_pending, sl_completed_now, sl_lat_rand, sl_fixed;
  int            sl_cnt, sl_lat;
  logic [DW-1:0] sl_fixed_data;
  int            n_accept, n_inst_ready, n_data_ready, n_done, n_bus_en;

  bit mode_random, mode_keep_both;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic decide();
    if (inst_en || data_en) begin
      owner_data = data_en && (!inst_en || !last_data);
      if (owner_data) begin
        m_addr = data_addr; m_we = data_write_en; m_wd = data_write_data;
      end else begin
        m_addr = inst_addr; m_we = '0; m_wd = '0;
      end
      in_flight  = 1'b1;
      idle       = 1'b0;
      exp_bus_en = 1'b1;
      grant_q.push_back(owner_data);
    end
  endtask

  task automatic present();
    if (idle && !in_flight) decide();
  endtask

  task automatic raise_inst();
    inst_en = 1'b1; inst_addr = $urandom;
  endtask

  task automatic raise_data();
    data_en = 1'b1; data_addr = $urandom;
    data_write_en   = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom);
    data_write_data = $urandom;
  endtask

  task automatic drive_masters();
    if (mode_keep_both) begin
      if (!inst_en) raise_inst();
      if (!data_en) raise_data();
    end else if (mode_random) begin
      if (!inst_en && !(in_flight && !owner_data) && $urandom_range(0, 3) == 0) raise_inst();
      if (!data_en && !(in_flight && owner_data) && $urandom_range(0, 3) == 0) raise_data();
      if (in_flight && !owner_data && inst_en && $urandom_range(0, 7) == 0) inst_en = 1'b0;
      if (in_flight && owner_data && data_en && $urandom_range(0, 7) == 0) data_en = 1'b0;
    end
  endtask

  // One clock cycle: check outputs, advance slave and model, drive masters.
  task automatic step();
    bit done_now;
    @(negedge clk);
    if (idle_pending) begin idle = 1'b1; idle_pending = 1'b0; end
    check("bus_en", bus_en, exp_bus_en);
    check("inst_ready", inst_ready, exp_done && !owner_data);
    check("data_ready", data_ready, exp_done && owner_data);
    check("inst_read_data", inst_read_data, m_inst_rd);
    check("data_read_data", data_read_data, m_data_rd);
    if (in_flight) begin
      check("bus_addr", bus_addr, m_addr);
      check("bus_write_en", bus_write_en, m_we);
      check("bus_write_data", bus_write_data, m_wd);
    end
    if (inst_ready) n_inst_ready++;
    if (data_ready) n_data_ready++;
    if (bus_en) n_bus_en++;
    done_now = exp_done;
    exp_done = 1'b0;
    sl_completed_now = 1'b0;
    if (sl_accept_pending) begin
      bus_ready = 1'b0;
      sl_cnt = sl_lat_rand ? $urandom_range(1, 6) : sl_lat;
      sl_accept_pending = 1'b0;
    end else if (sl_cnt > 0) begin
      sl_cnt--;
      if (sl_cnt == 0) begin
        bus_ready        = 1'b1;
        bus_read_data    = sl_fixed ? sl_fixed_data : $urandom;
        sl_completed_now = 1'b1;
        exp_done         = 1'b1;
        if (!owner_data)     m_inst_rd = bus_read_data;
        else if (m_we == '0) m_data_rd = bus_read_data;
      end
    end else if (bus_en && bus_ready) begin
      sl_accept_pending = 1'b1;
      n_accept++;
      exp_bus_en = 1'b0;
    end
    if (done_now) begin
      n_done++;
      in_flight = 1'b0;
      last_data = owner_data;
      idle_pending = 1'b1;
      if (owner_data) data_en = 1'b0;
      else            inst_en = 1'b0;
    end
    drive_masters();
    if (idle && !in_flight) decide();
  endtask

  task automatic wait_done(input string tag, input int max, output int steps);
    int start;
    start = n_done;
    steps = 0;
    while (n_done == start && steps < max) begin
      step();
      steps++;
    end
    check(tag, n_done != start, 1'b1);
  endtask

  task automatic model_reset();
    idle = 1'b1; idle_pending = 1'b0; in_flight = 1'b0;
    owner_data = 1'b0; last_data = 1'b0;
    m_addr = '0; m_we = '0; m_wd = '0; m_inst_rd = '0; m_data_rd = '0;
    exp_bus_en = 1'b0; exp_done = 1'b0;
    sl_accept_pending = 1'b0; sl_cnt = 0; sl_completed_now = 1'b0;
    bus_ready = 1'b1; bus_read_data = '0;
  endtask

  // Assert rst mid low-phase, check the asynchronous clear, release on a negedge.
  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_bus_en", bus_en, 1'b0);
    check("rst_inst_ready", inst_ready, 1'b0);
    check("rst_data_ready", data_ready, 1'b0);
    check("rst_inst_read_data", inst_read_data, '0);
    check("rst_data_read_data", data_read_data, '0);
    check("rst_bus_addr", bus_addr, '0);
    check("rst_bus_write_en", bus_write_en, '0);
    check("rst_bus_write_data", bus_write_data, '0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    decide();
  endtask

  initial begin
    int steps, a0, d0, i0, b0;
    rst = 1'b1;
    inst_en = 1'b0; data_en = 1'b0;
    inst_addr = '0; data_addr = '0; data_write_en = '0; data_write_data = '0;
    sl_lat = 1; sl_lat_rand = 1'b0; sl_fixed = 1'b0; sl_fixed_data = '0;
    n_accept = 0; n_inst_ready = 0; n_data_ready = 0; n_done = 0; n_bus_en = 0;
    mode_random = 1'b0; mode_keep_both = 1'b0;
    model_reset();
    @(negedge clk);
    apply_reset();

    // Minimum latency: ready pulse four cycles after the request is seen
    sl_lat = 1;
    inst_addr = 32'h0000_0040; inst_en = 1'b1; present();
    wait_done("min_latency_timeout", 20, steps);
    check("min_latency_cycles", steps, 4);

    // Data word write leaves the load register untouched
    sl_lat = 2;
    data_addr = 32'h8000_1000; data_write_en = 4'b1111;
    data_write_data = 32'hDEAD_BEEF; data_en = 1'b1; present();
    wait_done("write_timeout", 20, steps);
    check("write_data_read_data", data_read_data, 32'h0);
    check("write_last_grant_was_data", grant_q[grant_q.size()-1], 1'b1);

    // Instruction read with a fixed slave word
    sl_fixed = 1'b1; sl_fixed_data = 32'h3C1D_0001;
    d0 = n_data_ready;
    inst_addr = 32'hBFC0_0000; inst_en = 1'b1; present();
    wait_done("inst_read_timeout", 20, steps);
    repeat (3) step();
    check("inst_read_word", inst_read_data, 32'h3C1D_0001);
    check("inst_read_no_data_ready", n_data_ready - d0, 0);
    sl_fixed = 1'b0;

    // Contention: both held, grants must alternate starting with data
    grant_q.delete();
    i0 = n_inst_ready; d0 = n_data_ready;
    mode_keep_both = 1'b1;
    for (int k = 0; k < 4; k++) wait_done("contention_timeout", 30, steps);
    mode_keep_both = 1'b0;
    inst_en = 1'b0; data_en = 1'b0;
    check("contention_grants", grant_q.size(), 4);
    if (grant_q.size() == 4) begin
      check("contention_g0", grant_q[0], 1'b1);
      check("contention_g1", grant_q[1], 1'b0);
      check("contention_g2", grant_q[2], 1'b1);
      check("contention_g3", grant_q[3], 1'b0);
    end
    check("contention_inst_pulses", n_inst_ready - i0, 2);
    check("contention_data_pulses", n_data_ready - d0, 2);

    // Master drops en the cycle after grant
    sl_lat = 3;
    a0 = n_accept; d0 = n_data_ready; b0 = n_bus_en;
    data_addr = $urandom; data_write_en = '0; data_en = 1'b1; present();
    for (int k = 0; k < 10 && !in_flight; k++) step();
    step();
    data_en = 1'b0;
    wait_done("drop_timeout", 30, steps);
    repeat (5) step();
    check("drop_single_accept", n_accept - a0, 1);
    check("drop_ready_pulse", n_data_ready - d0, 1);
    check("drop_single_bus_en", n_bus_en - b0, 1);

    // Slow slave: ten busy cycles
    sl_lat = 10;
    b0 = n_bus_en;
    data_addr = $urandom; data_write_en = '0; data_en = 1'b1; present();
    wait_done("slow_timeout", 40, steps);
    check("slow_bus_en_cycles", n_bus_en - b0, 1);
    check("slow_latency_cycles", steps, 13);

    // Reset in WAIT_HIGH, then data-first tie-break on the pending pair
    sl_lat = 4;
    i0 = n_inst_ready;
    inst_addr = $urandom; inst_en = 1'b1; present();
    for (int k = 0; k < 20 && !sl_completed_now; k++) step();
    check("rst_reached_wait_high", sl_completed_now, 1'b1);
    data_addr = $urandom; data_write_en = '0; data_en = 1'b1;
    grant_q.delete();
    apply_reset();
    check("rst_no_pulse", n_inst_ready - i0, 0);
    wait_done("post_rst_first", 30, steps);
    wait_done("post_rst_second", 30, steps);
    check("post_rst_grants", grant_q.size(), 2);
    if (grant_q.size() == 2) begin
      check("post_rst_g0_data", grant_q[0], 1'b1);
      check("post_rst_g1_inst", grant_q[1], 1'b0);
    end

    // Randomized traffic, then drain
    sl_lat_rand = 1'b1;
    mode_random = 1'b1;
    repeat (1500) step();
    mode_random = 1'b0;
    for (int k = 0; k < 300 && (inst_en || data_en || in_flight); k++) step();
    check("drain_complete", inst_en || data_en || in_flight, 1'b0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
